hdmi_pattern_gen: RTL and testbench

Parametrised test-pattern source for the HDMI TX path. It answers the HDMI TX controller's pixel requests (`req_en`/`req_sof`/`req_sol`) with RGB888 pixels exactly `RESP_LATENCY` cycles later. It supports four selectable patterns: scrolling gradient, 8 colour bars, checkerboard and solid colour. It sits between the top level and `hdmi_tx_top`, in the same pixel-clock domain.

---
 rtl/hdmi_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_hdmi_pattern_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_gen.sv
// Test-pattern pixel source answering HDMI TX pixel requests with RGB888 pixels.
// Latency RESP_LATENCY cycles, fully pipelined; no backpressure, one response per request.
module hdmi_pattern_gen #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          RESP_LATENCY = 1,
  parameter int          SCROLL_STEP  = 1,
  parameter int          CHECK_LOG2   = 5,
  parameter logic [23:0] SOLID_RGB    = 24'hFF8000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  mode,
  input  logic        req_en,
  input  logic        req_sof,
  input  logic        req_sol,
  output logic [7:0]  resp_red,
  output logic [7:0]  resp_green,
  output logic [7:0]  resp_blue,
  output logic [15:0] frame_cnt
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    ofs_q, ofs_d;
  logic [7:0]    ofs_acc_q;
  logic [15:0]   frame_cnt_q;

  logic [15:0]   x_ext;
  logic [7:0]    ramp;
  logic [2:0]    bar;
  logic          chk_white;
  pix_t          pix_d;

  pix_t                    pix_pipe [RESP_LATENCY];
  logic [RESP_LATENCY-1:0] vld_pipe;
  pix_t                    out_pix;

  // Next coordinate / frame state; the pixel below is computed from these so
  // an SOF request already sees its own new mode and offset.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    ofs_d  = ofs_q;
    if (req_en) begin
      if (req_sof) begin
        x_d    = '0;
        y_d    = '0;
        mode_d = mode;
        ofs_d  = ofs_acc_q;
      end else if (req_sol) begin
        x_d = '0;
        y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = (x_q == XW'(H_ACTIVE - 1)) ? '0 : x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      ofs_q       <= '0;
      ofs_acc_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      ofs_q  <= ofs_d;
      if (req_en && req_sof) begin
        ofs_acc_q   <= ofs_acc_q + 8'(SCROLL_STEP);
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    x_ext     = 16'(x_d);
    ramp      = x_ext[7:0] + ofs_d;
    chk_white = 1'(x_d >> CHECK_LOG2) ^ 1'(y_d >> CHECK_LOG2);
    // Bar thresholds fold to constants; last matching threshold wins.
    bar = '0;
    for (int b = 1; b < 8; b++) begin
      if (x_ext >= 16'((H_ACTIVE * b) / 8)) bar = 3'(b);
    end
    pix_d = '0;
    case (mode_d)
      2'd0: pix_d = {ramp, ~ramp, ramp};
      2'd1: begin
        case (bar)
          3'd0:    pix_d = 24'hFFFFFF;
          3'd1:    pix_d = 24'hFFFF00;
          3'd2:    pix_d = 24'h00FFFF;
          3'd3:    pix_d = 24'h00FF00;
          3'd4:    pix_d = 24'hFF00FF;
          3'd5:    pix_d = 24'hFF0000;
          3'd6:    pix_d = 24'h0000FF;
          default: pix_d = 24'h000000;
        endcase
      end
      2'd2:    pix_d = chk_white ? 24'hFFFFFF : 24'h000000;
      default: pix_d = SOLID_RGB;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RESP_LATENCY; i++) pix_pipe[i] <= '0;
      vld_pipe <= '0;
    end else begin
      pix_pipe[0] <= req_en ? pix_d : '0;
      vld_pipe[0] <= req_en;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pix_pipe[i] <= pix_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign out_pix    = vld_pipe[RESP_LATENCY-1] ? pix_pipe[RESP_LATENCY-1] : '0;
  assign resp_red   = out_pix.r;
  assign resp_green = out_pix.g;
  assign resp_blue  = out_pix.b;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: two differently parameterised instances share one
// request stream and are checked every cycle against a frame/line/pixel model.
module tb_hdmi_pattern_gen;

  localparam int          HA = 16, VA = 4, LA = 1, SA = 3, CA = 1;
  localparam logic [23:0] SOLA = 24'hFF8000;
  localparam int          HB = 20, VB = 3, LB = 4, SB = 5, CB = 0;
  localparam logic [23:0] SOLB = 24'h123456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, req_en, req_sof, req_sol;
  logic [1:0]  mode;
  logic [7:0]  ra, ga, ba, rb, gb, bb;
  logic [15:0] fca, fcb;

  hdmi_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .RESP_LATENCY(LA), .SCROLL_STEP(SA),
                     .CHECK_LOG2(CA), .SOLID_RGB(SOLA)) dut_a (
    .clk(clk), .rstn(rstn), .mode(mode), .req_en(req_en), .req_sof(req_sof),
    .req_sol(req_sol), .resp_red(ra), .resp_green(ga), .resp_blue(ba), .frame_cnt(fca));

  hdmi_pattern_gen #(.H_ACTIVE(HB), .V_ACTIVE(VB), .RESP_LATENCY(LB), .SCROLL_STEP(SB),
                     .CHECK_LOG2(CB), .SOLID_RGB(SOLB)) dut_b (
    .clk(clk), .rstn(rstn), .mode(mode), .req_en(req_en), .req_sof(req_sof),
    .req_sol(req_sol), .resp_red(rb), .resp_green(gb), .resp_blue(bb), .frame_cnt(fcb));

  int n_chk = 0, n_fail = 0;
  int cyc = 0, cur_idx = 0;
  logic chk_on = 1'b0;

  logic [23:0] exp_pix [2];
  logic [15:0] exp_fc  [2];
  logic [23:0] log_a [4096];
  logic [23:0] log_b [4096];
  logic [15:0] fclog_a [4096];

  int          ph [2], pv [2], ps [2], pc [2];
  logic [23:0] psol [2];
  int          mx [2], my [2], mk [2];
  logic [1:0]  mmode [2];
  logic [7:0]  mofs [2];
  logic [15:0] mfc [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];
  logic [23:0] bar_tab [8];
  logic [23:0] chk_tab [10];

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, req);
    end
  endtask

  function automatic logic [23:0] pattern(input int d);
    int v, bar;
    case (mmode[d])
      2'd0: begin
        v = (mx[d] + int'(mofs[d])) % 256;
        return {8'(v), ~8'(v), 8'(v)};
      end
      2'd1: begin
        bar = 0;
        for (int b = 0; b < 8; b++) if (mx[d] >= (ph[d] * b) / 8) bar = b;
        return bar_tab[bar];
      end
      2'd2: return ((((mx[d] >> pc[d]) ^ (my[d] >> pc[d])) & 1) != 0) ? 24'hFFFFFF : 24'h0;
      default: return psol[d];
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; mk[d] = 0; mmode[d] = 2'd0; mofs[d] = 8'd0; mfc[d] = 16'd0;
    end
    q0.delete();
    q1.delete();
    repeat (LA - 1) q0.push_back(24'h0);
    repeat (LB - 1) q1.push_back(24'h0);
  endtask

  task automatic model_req(input logic en, input logic sof, input logic sol, input logic [1:0] md);
    logic [23:0] pix;
    for (int d = 0; d < 2; d++) begin
      pix = 24'h0;
      if (en) begin
        if (sof) begin
          mx[d] = 0; my[d] = 0; mmode[d] = md;
          mofs[d] = 8'((mk[d] * ps[d]) % 256);
          mk[d]++;
          mfc[d] = mfc[d] + 16'd1;
        end else if (sol) begin
          mx[d] = 0;
          my[d] = (my[d] == pv[d] - 1) ? 0 : my[d] + 1;
        end else begin
          mx[d] = (mx[d] == ph[d] - 1) ? 0 : mx[d] + 1;
        end
        pix = pattern(d);
      end
      if (d == 0) q0.push_back(pix);
      else        q1.push_back(pix);
    end
  endtask

  task automatic step(input logic en, input logic sof, input logic sol, input logic [1:0] md);
    req_en = en; req_sof = sof; req_sol = sol; mode = md;
    model_req(en, sof, sol, md);
    @(posedge clk);
    #1;
    exp_pix[0] = q0.pop_front();
    exp_pix[1] = q1.pop_front();
    exp_fc[0]  = mfc[0];
    exp_fc[1]  = mfc[1];
    cur_idx = cyc;
    cyc++;
  endtask

  task automatic rand_inputs();
    req_en = 1'($urandom); req_sof = 1'($urandom); req_sol = 1'($urandom); mode = 2'($urandom);
  endtask

  // Reset is asserted between clock edges so its asynchronous effect is visible.
  task automatic do_reset(input int n);
    rstn = 1'b0;
    rand_inputs();
    #1;
    model_reset();
    exp_pix[0] = 24'h0; exp_pix[1] = 24'h0;
    exp_fc[0]  = 16'h0; exp_fc[1]  = 16'h0;
    chk_on = 1'b1;
    repeat (n) begin
      rand_inputs();
      @(posedge clk);
      #1;
      cur_idx = cyc;
      cyc++;
    end
    check("rst_resp_a", {ra, ga, ba}, 24'h0);
    check("rst_fc_b", {8'h0, fcb}, 24'h0);
    rstn = 1'b1;
    req_en = 1'b0; req_sof = 1'b0; req_sol = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("resp_a", {ra, ga, ba}, exp_pix[0]);
      check("fc_a", {8'h0, fca}, {8'h0, exp_fc[0]});
      check("resp_b", {rb, gb, bb}, exp_pix[1]);
      check("fc_b", {8'h0, fcb}, {8'h0, exp_fc[1]});
      log_a[cur_idx]   = {ra, ga, ba};
      log_b[cur_idx]   = {rb, gb, bb};
      fclog_a[cur_idx] = fca;
    end
  end

  initial begin
    int s3, sl, sb, sc, sm, sr;
    logic [3:0] chk_seq [10];
    ph[0] = HA; pv[0] = VA; ps[0] = SA; pc[0] = CA; psol[0] = SOLA;
    ph[1] = HB; pv[1] = VB; ps[1] = SB; pc[1] = CB; psol[1] = SOLB;
    bar_tab = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    chk_tab = '{24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
    // {en, sof, sol, -} per checker-phase cycle
    chk_seq = '{4'b1100, 4'b1000, 4'b0000, 4'b1000, 4'b1000,
                4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    rstn = 1'b0; req_en = 1'b0; req_sof = 1'b0; req_sol = 1'b0; mode = 2'd0;
    model_reset();

    do_reset(5);
    repeat (2) step(0, 0, 0, 0);

    // Scroll: three frames in mode 0
    s3 = 0;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) s3 = cyc;
      step(1, 1, 0, 0);
      repeat (3) step(1, 0, 0, 0);
    end
    repeat (4) step(0, 0, 0, 0);
    check("scroll_f2_a", log_a[s3], 24'h06F906);
    check("scroll_fc_a", {8'h0, fclog_a[s3]}, 24'd3);
    check("scroll_f2_b", log_b[s3 + LB - 1], 24'h0AF50A);

    // Latency: single solid-colour SOF
    sl = cyc;
    step(1, 1, 0, 3);
    repeat (6) step(0, 0, 0, 0);
    check("lat_a_before", log_a[sl - 1], 24'h0);
    check("lat_a_hit", log_a[sl], 24'hFF8000);
    check("lat_a_after", log_a[sl + 1], 24'h0);
    check("lat_b_before", log_b[sl + 2], 24'h0);
    check("lat_b_hit", log_b[sl + 3], 24'h123456);
    check("lat_b_after", log_b[sl + 4], 24'h0);

    // Colour bars: one full line of A
    sb = cyc;
    step(1, 1, 0, 1);
    repeat (15) step(1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) check("bars_a", log_a[sb + i], bar_tab[i / 2]);
    check("bars_b_x1", log_b[sb + LB - 1 + 1], 24'hFFFFFF);
    check("bars_b_x2", log_b[sb + LB - 1 + 2], 24'hFFFF00);

    // Checker with a mid-line gap and two SOLs
    sc = cyc;
    for (int i = 0; i < 10; i++) step(chk_seq[i][3], chk_seq[i][2], chk_seq[i][1], 2);
    repeat (4) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) check("checker_a", log_a[sc + i], chk_tab[i]);

    // Mode change mid-frame takes effect only at the next SOF
    sm = cyc;
    step(1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    check("latch_mid_a", log_a[sm + 3], 24'h15EA15);
    check("latch_sof_a", log_a[sm + 5], 24'hFFFFFF);

    // Random traffic
    repeat (2000)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)));

    // Reset in the middle of a frame with responses in flight
    step(1, 1, 0, 2);
    repeat (3) step(1, 0, 0, 2);
    do_reset(3);
    sr = cyc;
    step(1, 0, 0, 2);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check("post_rst_a_x1", log_a[sr], 24'h01FE01);
    check("post_rst_a_x2", log_a[sr + 1], 24'h02FD02);
    check("post_rst_b_x1", log_b[sr + LB - 1], 24'h01FE01);
    check("post_rst_fc_a", {8'h0, fclog_a[sr]}, 24'h0);

    repeat (300)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
    repeat (LB) step(0, 0, 0, 0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
